// File: rtl/vu_bank_regfile_param.sv
// vu_bank_regfile_param
//   Single-bank 1R1W register file (DEPTH x DATA_W) with a selectable
//   write source, a registered read port with write-first bypass, NOPL
//   operand latches fed from the read data, and an optional zero-fill
//   scrub of the whole array after every reset release.
// Ports
//   clk       : clock, all state changes on the rising edge
//   reset     : asynchronous active-low reset
//   ren/raddr : read request / address (result one cycle later)
//   roplen    : per-latch capture enable, loads current rdata
//   wen/waddr : write request / address
//   wsel      : write-source select (>= NWPORT writes zero, flags error)
//   wdata_in  : NWPORT packed write sources, source k at [k*DATA_W +: DATA_W]
//   rdata     : registered read data, holds when no read is accepted
//   rvalid    : rdata refreshed this cycle
//   ropl      : operand latches, latch i at [i*DATA_W +: DATA_W]
//   ready     : array initialised, requests accepted
//   wsel_err  : out-of-range wsel written last cycle
module vu_bank_regfile_param #(
  parameter int DATA_W   = 65,
  parameter int DEPTH    = 256,
  parameter int NWPORT   = 5,
  parameter int NOPL     = 2,
  parameter int SCRUB_EN = 1,
  localparam int ADDR_W  = $clog2(DEPTH),
  localparam int SEL_W   = $clog2(NWPORT + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ren,
  input  logic [ADDR_W-1:0]        raddr,
  input  logic [NOPL-1:0]          roplen,
  input  logic                     wen,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [SEL_W-1:0]         wsel,
  input  logic [NWPORT*DATA_W-1:0] wdata_in,
  output logic [DATA_W-1:0]        rdata,
  output logic                     rvalid,
  output logic [NOPL*DATA_W-1:0]   ropl,
  output logic                     ready,
  output logic                     wsel_err
);

  localparam logic [1:0] ST_RST   = 2'd0;
  localparam logic [1:0] ST_SCRUB = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              rd_acc;
  logic              wr_acc;
  logic              raddr_ok;
  logic              waddr_ok;
  logic              sel_oor;
  logic [DATA_W-1:0] wdata_sel;

  assign ready    = (state == ST_READY);
  assign rd_acc   = ready && ren;
  assign wr_acc   = ready && wen;
  // Extra top bit keeps the compare meaningful when DEPTH is a power of 2.
  assign raddr_ok = ({1'b0, raddr} < DEPTH_L);
  assign waddr_ok = ({1'b0, waddr} < DEPTH_L);
  assign sel_oor  = (wsel >= SEL_W'(NWPORT));

  always_comb begin
    wdata_sel = '0;
    for (int unsigned k = 0; k < NWPORT; k++) begin
      if (wsel == SEL_W'(k)) wdata_sel = wdata_in[k*DATA_W +: DATA_W];
    end
  end

  // Init sequencer: RST -> (SCRUB for DEPTH cycles) -> READY (terminal).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_RST;
      cnt   <= '0;
    end else begin
      case (state)
        ST_RST: begin
          cnt   <= '0;
          state <= (SCRUB_EN != 0) ? ST_SCRUB : ST_READY;
        end
        ST_SCRUB: begin
          if (cnt == LAST) state <= ST_READY;
          else             cnt   <= cnt + ADDR_W'(1);
        end
        default: state <= state;
      endcase
    end
  end

  // Storage array: no reset so it can map onto RAM. Scrub and user writes
  // are mutually exclusive because requests are only accepted in READY.
  always_ff @(posedge clk) begin
    if (state == ST_SCRUB)        mem[cnt]   <= '0;
    else if (wr_acc && waddr_ok)  mem[waddr] <= wdata_sel;
  end

  // Read port, error flag and operand latches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata    <= '0;
      rvalid   <= 1'b0;
      wsel_err <= 1'b0;
      ropl     <= '0;
    end else begin
      rvalid   <= rd_acc;
      wsel_err <= wr_acc && sel_oor;
      if (rd_acc) begin
        if (!raddr_ok)                        rdata <= '0;
        else if (wr_acc && (waddr == raddr))  rdata <= wdata_sel;
        else                                  rdata <= mem[raddr];
      end
      for (int unsigned i = 0; i < NOPL; i++) begin
        if (roplen[i]) ropl[i*DATA_W +: DATA_W] <= rdata;
      end
    end
  end

endmodule

// File: tb/tb_vu_bank_regfile_param.sv
module tb_vu_bank_regfile_param;

  localparam int DW = 65;
  localparam int NW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: defaults (DEPTH=256, scrub enabled)
  logic             reset;
  logic             ren, wen;
  logic [7:0]       raddr, waddr;
  logic [1:0]       roplen;
  logic [2:0]       wsel;
  logic [NW*DW-1:0] wdata_in;
  logic [DW-1:0]    rdata;
  logic             rvalid, ready, wsel_err;
  logic [2*DW-1:0]  ropl;

  // Instance B: DEPTH=12, no scrub
  logic             b_reset;
  logic             b_ren, b_wen;
  logic [3:0]       b_raddr, b_waddr;
  logic [1:0]       b_roplen;
  logic [2:0]       b_wsel;
  logic [NW*DW-1:0] b_wdata_in;
  logic [DW-1:0]    b_rdata;
  logic             b_rvalid, b_ready, b_wsel_err;
  logic [2*DW-1:0]  b_ropl;

  vu_bank_regfile_param dut (
    .clk(clk), .reset(reset), .ren(ren), .raddr(raddr), .roplen(roplen),
    .wen(wen), .waddr(waddr), .wsel(wsel), .wdata_in(wdata_in),
    .rdata(rdata), .rvalid(rvalid), .ropl(ropl), .ready(ready),
    .wsel_err(wsel_err)
  );

  vu_bank_regfile_param #(.DATA_W(65), .DEPTH(12), .NWPORT(5), .NOPL(2), .SCRUB_EN(0)) dut_b (
    .clk(clk), .reset(b_reset), .ren(b_ren), .raddr(b_raddr), .roplen(b_roplen),
    .wen(b_wen), .waddr(b_waddr), .wsel(b_wsel), .wdata_in(b_wdata_in),
    .rdata(b_rdata), .rvalid(b_rvalid), .ropl(b_ropl), .ready(b_ready),
    .wsel_err(b_wsel_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model of instance A (valid while ready)
  logic [DW-1:0] m_mem [256];
  logic [DW-1:0] m_rdata;
  logic          m_rvalid;
  logic          m_err;
  logic [DW-1:0] m_opl [2];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd65();
    return {1'($urandom()), $urandom(), $urandom()};
  endfunction

  task automatic model_reset();
    foreach (m_mem[a]) m_mem[a] = '0;  // after a completed scrub
    m_rdata = '0; m_rvalid = 1'b0; m_err = 1'b0;
    m_opl[0] = '0; m_opl[1] = '0;
  endtask

  // One clock with instance A in READY: predict from the rules, then compare.
  task automatic cyc(input string tag);
    logic [DW-1:0] wd;
    wd = (wsel < 3'd5) ? wdata_in[int'(wsel)*DW +: DW] : '0;
    for (int i = 0; i < 2; i++) if (roplen[i]) m_opl[i] = m_rdata;
    m_err = wen && (wsel >= 3'd5);
    if (wen) m_mem[waddr] = wd;          // write-first
    m_rvalid = ren;
    if (ren) m_rdata = m_mem[raddr];
    @(posedge clk); #1;
    chk({tag, ".rdata"},  rdata,    m_rdata);
    chk({tag, ".rvalid"}, rvalid,   m_rvalid);
    chk({tag, ".err"},    wsel_err, m_err);
    chk({tag, ".ropl"},   ropl,     {m_opl[1], m_opl[0]});
    chk({tag, ".ready"},  ready,    1'b1);
  endtask

  task automatic idle_a();
    ren = 1'b0; wen = 1'b0; roplen = 2'b00; wsel = 3'd0;
  endtask

  // Release reset and count edges until ready, hammering requests meanwhile.
  task automatic release_and_scrub(input string tag);
    int n;
    n = 0;
    ren = 1'b1; wen = 1'b1; wsel = 3'd7; roplen = 2'b00;
    reset = 1'b1;
    while (n < 400) begin
      @(posedge clk); #1;
      n++;
      if (ready) break;
      chk({tag, ".scrub_rvalid"}, rvalid,   1'b0);
      chk({tag, ".scrub_err"},    wsel_err, 1'b0);
      ren   = 1'($urandom());
      wen   = 1'($urandom());
      raddr = 8'($urandom());
      waddr = 8'($urandom());
      wsel  = 3'($urandom_range(0, 7));
      for (int k = 0; k < NW; k++) wdata_in[k*DW +: DW] = rnd65();
    end
    chk({tag, ".ready_edges"}, n, 257);
    idle_a();
  endtask

  task automatic chk_a_zero(input string tag);
    chk({tag, ".rdata"},  rdata,    '0);
    chk({tag, ".rvalid"}, rvalid,   1'b0);
    chk({tag, ".ropl"},   ropl,     '0);
    chk({tag, ".ready"},  ready,    1'b0);
    chk({tag, ".err"},    wsel_err, 1'b0);
  endtask

  task automatic b_cyc();
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; b_reset = 1'b0;
    idle_a(); raddr = '0; waddr = '0; wdata_in = '0;
    b_ren = 1'b0; b_wen = 1'b0; b_raddr = '0; b_waddr = '0;
    b_roplen = 2'b00; b_wsel = 3'd0; b_wdata_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_a_zero("rst");
    chk("b_rst.ready", b_ready, 1'b0);
    chk("b_rst.rdata", b_rdata, '0);

    // Scrub with ignored requests, then full readback of zeros
    release_and_scrub("scrub1");
    model_reset();
    for (int a = 0; a < 256; a++) begin
      ren = 1'b1; raddr = 8'(a);
      cyc("readback");
    end
    idle_a();

    // Source select and out-of-range wsel
    wdata_in[3*DW +: DW] = 65'h1_2345_6789_ABCD_EF01;
    wen = 1'b1; waddr = 8'd7; wsel = 3'd3;                 cyc("wr7");
    wen = 1'b0; ren = 1'b1; raddr = 8'd7;                  cyc("rd7");
    chk("rd7.const", rdata, 65'h1_2345_6789_ABCD_EF01);
    wdata_in[1*DW +: DW] = 65'h1F; ren = 1'b0;
    wen = 1'b1; waddr = 8'd8; wsel = 3'd1;                 cyc("wr8a");
    wsel = 3'd6;                                           cyc("wr8b");
    chk("wr8b.err_const", wsel_err, 1'b1);
    wen = 1'b0;                                            cyc("err_clear");
    chk("err_clear.const", wsel_err, 1'b0);
    ren = 1'b1; raddr = 8'd8;                              cyc("rd8");
    chk("rd8.const", rdata, '0);
    idle_a();

    // Bypass
    wdata_in[0 +: DW] = 65'h55;
    wen = 1'b1; waddr = 8'h41; wsel = 3'd0;                cyc("wr41");
    wdata_in[0 +: DW] = 65'hAA;
    ren = 1'b1; raddr = 8'h40; waddr = 8'h40;              cyc("byp40");
    chk("byp40.const", rdata, 65'hAA);
    wdata_in[0 +: DW] = 65'hBB; raddr = 8'h41;             cyc("nobyp41");
    chk("nobyp41.const", rdata, 65'h55);
    idle_a();

    // Operand latches
    wen = 1'b1; wsel = 3'd0;
    waddr = 8'd1; wdata_in[0 +: DW] = 65'd5;               cyc("wr1");
    waddr = 8'd2; wdata_in[0 +: DW] = 65'd9;               cyc("wr2");
    wen = 1'b0; ren = 1'b1; raddr = 8'd1;                  cyc("rdop1");
    ren = 1'b0; roplen = 2'b01;                            cyc("cap0");
    roplen = 2'b00; ren = 1'b1; raddr = 8'd2;              cyc("rdop2");
    ren = 1'b0; roplen = 2'b10;                            cyc("cap1");
    roplen = 2'b00;
    repeat (3) cyc("ophold");
    chk("ropl0.const", ropl[0 +: DW],  65'd5);
    chk("ropl1.const", ropl[DW +: DW], 65'd9);

    // Randomised traffic against the model
    for (int t = 0; t < 1500; t++) begin
      ren    = 1'($urandom());
      wen    = 1'($urandom());
      roplen = 2'($urandom());
      wsel   = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) begin
        raddr = 8'($urandom_range(0, 7));
        waddr = 8'($urandom_range(0, 7));
      end else begin
        raddr = 8'($urandom());
        waddr = 8'($urandom());
      end
      for (int k = 0; k < NW; k++) wdata_in[k*DW +: DW] = rnd65();
      cyc("rand");
    end
    idle_a(); ren = 1'b1; raddr = 8'd7; cyc("pre_rst");
    ren = 1'b0; roplen = 2'b11; cyc("pre_rst2");
    idle_a();

    // Reset mid-operation: asynchronous clear
    reset = 1'b0; #1;
    chk_a_zero("async_rst");
    @(posedge clk); @(posedge clk); #1;
    chk_a_zero("held_rst");

    // Release, reset again at scrub cnt=100, then a full rescrub
    reset = 1'b1;
    repeat (101) @(posedge clk);
    #1;
    reset = 1'b0; #1;
    chk_a_zero("midscrub_rst");
    @(posedge clk); @(posedge clk); #1;
    release_and_scrub("scrub2");
    model_reset();
    for (int a = 0; a < 256; a++) begin
      ren = 1'b1; raddr = 8'(a);
      cyc("readback2");
    end
    idle_a();

    // Instance B: no scrub, DEPTH=12
    b_reset = 1'b1; #1;
    chk("b.ready_before", b_ready, 1'b0);
    b_cyc();
    chk("b.ready_after", b_ready, 1'b1);
    b_wen = 1'b1; b_wsel = 3'd1;
    b_waddr = 4'd5;  b_wdata_in[1*DW +: DW] = 65'h1_0000_0000_0000_0123; b_cyc();
    b_waddr = 4'd11; b_wdata_in[1*DW +: DW] = 65'h0BEEF;                 b_cyc();
    b_waddr = 4'd13; b_wdata_in[1*DW +: DW] = 65'h0DEAD;                 b_cyc();
    chk("b.err13", b_wsel_err, 1'b0);
    b_wen = 1'b0; b_ren = 1'b1; b_raddr = 4'd13; b_cyc();
    chk("b.rd13", b_rdata, '0);
    chk("b.rd13_valid", b_rvalid, 1'b1);
    b_raddr = 4'd5;  b_cyc();
    chk("b.rd5", b_rdata, 65'h1_0000_0000_0000_0123);
    b_raddr = 4'd11; b_cyc();
    chk("b.rd11", b_rdata, 65'h0BEEF);
    b_wen = 1'b1; b_waddr = 4'd13; b_raddr = 4'd13; b_cyc();
    chk("b.byp13", b_rdata, '0);
    b_wen = 1'b0; b_ren = 1'b0; b_cyc();
    chk("b.idle_valid", b_rvalid, 1'b0);
    chk("b.hold", b_rdata, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
